// File: rtl/cic_dec_ctrl.sv
// cic_dec_ctrl: sequencing controller for a CIC decimator datapath.
//
// Gates the integrator chain, counts accepted input samples to produce the
// rate-R decimation strobe that clocks the comb chain, hides the comb-chain
// start-up transient behind a warm-up phase, and presents decimated outputs
// through a valid/ready handshake. Run-time rate changes are deferred to a
// decimation boundary and followed by a fresh warm-up.
//
// Ports:
//   clk        in   rising-edge clock
//   rstn       in   synchronous active-low reset
//   en         in   filter enable; low forces IDLE and flushes in-flight work
//   cfg_rate   in   requested decimation rate R (0 is illegal)
//   cfg_load   in   1-cycle request to load cfg_rate
//   in_valid   in   input sample present this cycle
//   out_ready  in   downstream accepts the current output
//   integ_en   out  integrator enable (combinational: in_valid & not IDLE)
//   dec_strobe out  comb-chain enable / downsampler capture pulse
//   out_valid  out  comb-chain output valid
//   state      out  0=IDLE, 1=WARMUP, 2=RUN
//   rate_q     out  active decimation rate
//   cfg_err    out  pulse: cfg_load with cfg_rate==0 was rejected
//   drop_cnt   out  saturating count of outputs lost to backpressure

module cic_dec_ctrl #(
    parameter int unsigned RATE_W    = 8,
    parameter int unsigned R_DEFAULT = 4,
    parameter int unsigned N_STAGES  = 4,
    parameter int unsigned N_DELAYS  = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [RATE_W-1:0] cfg_rate,
    input  logic              cfg_load,
    input  logic              in_valid,
    input  logic              out_ready,
    output logic              integ_en,
    output logic              dec_strobe,
    output logic              out_valid,
    output logic [1:0]        state,
    output logic [RATE_W-1:0] rate_q,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  drop_cnt
);

    // Strobes needed to flush the comb-chain start-up transient.
    localparam int unsigned WARM   = N_STAGES * N_DELAYS;
    localparam int unsigned WARM_W = $clog2(WARM + 1);
    // Token taps between the injecting strobe and the last comb stage.
    localparam int unsigned TOK_W  = (N_STAGES > 1) ? (N_STAGES - 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [RATE_W-1:0]   phase_q, phase_d;
    logic [RATE_W-1:0]   rate_d;
    logic [RATE_W-1:0]   pend_rate_q, pend_rate_d;
    logic                pend_q, pend_d;
    logic                rewarm_q, rewarm_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [TOK_W-1:0]    tok_q, tok_d;
    logic                strobe_d;
    logic                valid_d;
    logic                err_d;
    logic [CNT_W-1:0]    drop_d;

    logic                wrap_c;
    logic                inject_c;
    logic                arrive_c;
    logic                cfg_ok_c;

    assign state    = state_q;
    assign integ_en = in_valid & (state_q != S_IDLE);

    // Last sample of a decimation period is being accepted this cycle.
    assign wrap_c   = integ_en & (phase_q == (rate_q - RATE_W'(1)));
    // Only strobes seen in RUN carry a settled comb output.
    assign inject_c = dec_strobe & (state_q == S_RUN);
    assign cfg_ok_c = cfg_load & (cfg_rate != '0);

    // Token reaching the last comb stage; registered into out_valid so the
    // output appears N_STAGES cycles after its strobe.
    generate
        if (N_STAGES > 1) begin : g_pipe
            assign arrive_c = tok_q[TOK_W-1];
        end else begin : g_nopipe
            assign arrive_c = inject_c;
        end
    endgenerate

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rate_d      = rate_q;
        pend_d      = pend_q;
        pend_rate_d = pend_rate_q;
        rewarm_d    = 1'b0;
        warm_d      = warm_q;
        tok_d       = TOK_W'({tok_q, inject_c});
        strobe_d    = wrap_c;
        valid_d     = out_valid;
        err_d       = cfg_load & (cfg_rate == '0);
        drop_d      = drop_cnt;

        // Phase counter over accepted samples.
        if (integ_en) begin
            phase_d = wrap_c ? '0 : (phase_q + RATE_W'(1));
        end

        // Output handshake; a token landing on a stalled output is lost.
        if (arrive_c) begin
            if (out_valid && !out_ready && (drop_cnt != '1)) begin
                drop_d = drop_cnt + CNT_W'(1);
            end
            valid_d = 1'b1;
        end else if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end

        // Sequencing.
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_WARMUP;
                    phase_d = '0;
                    warm_d  = '0;
                end
            end
            S_WARMUP: begin
                if (dec_strobe) begin
                    warm_d = warm_q + WARM_W'(1);
                    if (warm_q == WARM_W'(WARM - 1)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The strobe following a rate switch still belonged to the old rate
        // (handled above); warm-up under the new rate starts afterwards.
        if (rewarm_q) begin
            state_d = S_WARMUP;
            warm_d  = '0;
        end

        // Rate loads: immediate in IDLE, otherwise deferred to a wrap.
        if (state_q == S_IDLE) begin
            if (cfg_ok_c) begin
                rate_d = cfg_rate;
            end
        end else begin
            if (wrap_c && pend_q) begin
                rate_d   = pend_rate_q;
                pend_d   = 1'b0;
                phase_d  = '0;
                rewarm_d = 1'b1;
            end
            // A load in the wrap cycle itself waits for the following wrap.
            if (cfg_ok_c) begin
                pend_d      = 1'b1;
                pend_rate_d = cfg_rate;
            end
        end

        // Disable flushes everything in flight; a coincident load is
        // treated as an IDLE load.
        if (!en) begin
            state_d     = S_IDLE;
            phase_d     = '0;
            warm_d      = '0;
            tok_d       = '0;
            valid_d     = 1'b0;
            strobe_d    = 1'b0;
            pend_d      = 1'b0;
            rewarm_d    = 1'b0;
            drop_d      = drop_cnt;
            rate_d      = cfg_ok_c ? cfg_rate : rate_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            rate_q      <= RATE_W'(R_DEFAULT);
            pend_q      <= 1'b0;
            pend_rate_q <= '0;
            rewarm_q    <= 1'b0;
            warm_q      <= '0;
            tok_q       <= '0;
            dec_strobe  <= 1'b0;
            out_valid   <= 1'b0;
            cfg_err     <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            rate_q      <= rate_d;
            pend_q      <= pend_d;
            pend_rate_q <= pend_rate_d;
            rewarm_q    <= rewarm_d;
            warm_q      <= warm_d;
            tok_q       <= tok_d;
            dec_strobe  <= strobe_d;
            out_valid   <= valid_d;
            cfg_err     <= err_d;
            drop_cnt    <= drop_d;
        end
    end

endmodule
